multiport_arbitrated_ram: RTL
=============================

Name: multiport_arbitrated_ram

Overview:
Parametrised N-port synchronous RAM with per-port request handshake and registered read data with a valid strobe.
- Same-cycle write-write collisions are resolved by fixed port priority.
- Loss of a collision and out-of-range accesses are reported as per-port flags.
- A mandatory clear sweep after reset zeroes the array before ports are released.
- Sits between the processor datapath/DMA masters and data memory, replacing simple unchecked multiport arrays.

Parameters:
MEM_DEPTH   4096  number of words; may be less than 2**ADDR_WIDTH
DATA_WIDTH  12    word width in bits
ADDR_WIDTH  12    address width per port
PORT_COUNT  2     number of ports, >=1; port 0 has highest priority

Ports:
clk        in   1                      rising-edge clock
reset      in   1                      synchronous, active-high reset
req        in   PORT_COUNT             per-port request, sampled only while ready=1
we         in   PORT_COUNT             per-port 1=write, 0=read; qualified by req
addr       in   ADDR_WIDTH*PORT_COUNT  flattened; port i = bits [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH]
wdata      in   DATA_WIDTH*PORT_COUNT  flattened write data, same slicing rule
ready      out  1                      1 = array in RUN state, requests accepted
rvalid     out  PORT_COUNT             per-port one-cycle pulse, read data valid
rdata      out  DATA_WIDTH*PORT_COUNT  flattened registered read data
wr_conflict out PORT_COUNT             one-cycle pulse, this port's write was dropped by priority
addr_err   out  PORT_COUNT             one-cycle pulse, address >= MEM_DEPTH

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- While reset=1:
  - state <= CLEAR, clear counter <= 0.
  - ready, rvalid, rdata, wr_conflict, addr_err are all 0.
  - Array contents are not modified.
- CLEAR state:
  - Each clock writes 0 to the address held in the clear counter, then increments the counter.
  - On the edge that writes address MEM_DEPTH-1, the state moves to RUN and ready is registered to 1.
  - ready therefore rises after exactly MEM_DEPTH edges with reset low.
  - req is ignored; no rvalid, wr_conflict or addr_err is raised.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- RUN state: ready=1; the block remains in RUN until reset.
- Accepted request: req[i]=1 while ready=1.
- Read (we[i]=0):
  - rdata slice i and rvalid[i]=1 appear on the next edge (latency 1).
  - rvalid[i] is 0 in any cycle with no accepted read on port i.
  - rdata slice i holds its last value when no read is accepted.
- Write (we[i]=1):
  - The array is updated at the edge.
  - rvalid[i] stays 0.
- Write-write collision:
  - Applies when ports i<j write the same in-range address in the same cycle.
  - The lowest index wins; every losing port's write is dropped.
  - wr_conflict[j]=1 on the next edge for each loser.
- Read-during-write, same address, different ports, same cycle: the read returns the old (pre-write) contents (read-first).
- Out-of-range address (addr >= MEM_DEPTH):
  - A write is dropped.
  - A read returns 0 with rvalid=1.
  - addr_err[i]=1 on the next edge.
- Reads from several ports to the same address are all served; they are not conflicts.
- All flags are registered one-cycle pulses aligned with rvalid timing.

Optional Feature:
Macro: MPRAM_WR_BYPASS_EN
- Defined: a read that collides with a same-cycle winning write to the same address returns the new write data (write-first forwarding).
- Defined: forwarding applies only to in-range addresses; a dropped losing write is never forwarded.
- Undefined: read-first behaviour as specified in Behaviour.

Test Plan:
1. Clear sweep: MEM_DEPTH=16; deassert reset -> ready=0 for 16 edges, ready=1 on the 16th edge; then read every address -> all rdata=0x000, rvalid=1 one cycle after each request.
2. Basic R/W: port0 writes 0xABC @0x005; next cycle port1 reads 0x005 -> port1 rdata=0xABC, rvalid[1]=1, rvalid[0]=0.
3. Collision: port0 writes 0x111 and port1 writes 0x222 @0x00A in the same cycle -> wr_conflict=2'b10; a later read of 0x00A returns 0x111.
4. Read-during-write: port0 writes 0x3C3 @0x004 while port1 reads 0x004 (old value 0x0F0) -> port1 rdata=0x0F0 without the macro, 0x3C3 with MPRAM_WR_BYPASS_EN.
5. Range error: MEM_DEPTH=16, ADDR_WIDTH=12; port1 writes 0x7FF @0x010, then reads 0x010 -> addr_err[1]=1 both times, read rdata=0, array unchanged.
6. Reset mid-sweep: assert reset at clear count 7 for one cycle -> sweep restarts at 0; ready rises 16 edges after reset deasserts; requests issued during CLEAR produce no rvalid.

Source files
------------

// File: rtl/multiport_arbitrated_ram.sv
// multiport_arbitrated_ram: N-port sync RAM, fixed-priority write arbitration,
// zeroing sweep after reset. Optional macro: MPRAM_WR_BYPASS_EN (write-first).
// Ports: clk, reset; req/we/addr/wdata (flattened per port) in;
// ready, rvalid, rdata (flattened), wr_conflict, addr_err out.
module multiport_arbitrated_ram #(
  parameter int MEM_DEPTH  = 4096,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int PORT_COUNT = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PORT_COUNT-1:0]            req,
  input  logic [PORT_COUNT-1:0]            we,
  input  logic [ADDR_WIDTH*PORT_COUNT-1:0] addr,
  input  logic [DATA_WIDTH*PORT_COUNT-1:0] wdata,
  output logic                             ready,
  output logic [PORT_COUNT-1:0]            rvalid,
  output logic [DATA_WIDTH*PORT_COUNT-1:0] rdata,
  output logic [PORT_COUNT-1:0]            wr_conflict,
  output logic [PORT_COUNT-1:0]            addr_err
);

  localparam int CW =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH+1)'(MEM_DEPTH);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] a       [PORT_COUNT];
  logic [CW-1:0]         idx     [PORT_COUNT];
  logic [DATA_WIDTH-1:0] d       [PORT_COUNT];
  logic [DATA_WIDTH-1:0] rd_word [PORT_COUNT];
  logic [PORT_COUNT-1:0] in_rng;
  logic [PORT_COUNT-1:0] wr_ok;
  logic [PORT_COUNT-1:0] rd_ok;
  logic [PORT_COUNT-1:0] lose;
  logic [PORT_COUNT-1:0] win;
  logic                  run;

  assign run   = (state == S_RUN);
  assign ready = run;

  for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
    assign a[g] = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign d[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign idx[g] = a[g][CW-1:0];
    assign in_rng[g] = ({1'b0, a[g]} < DEPTH);
    assign wr_ok[g] =
      run & req[g] & we[g] & in_rng[g];
    assign rd_ok[g] = run & req[g] & ~we[g];
  end

  // A write loses if any lower-index port writes
  // the same in-range address this cycle.
  always_comb begin
    lose = '0;
    for (int i = 1; i < PORT_COUNT; i++) begin
      for (int j = 0; j < i; j++) begin
        if (wr_ok[i] && wr_ok[j] && a[i] == a[j])
          lose[i] = 1'b1;
      end
    end
  end

  assign win = wr_ok & ~lose;

  always_comb begin
    for (int i = 0; i < PORT_COUNT; i++) begin
      rd_word[i] = '0;
      if (in_rng[i])
        rd_word[i] = mem[idx[i]];
`ifdef MPRAM_WR_BYPASS_EN
      // Winners hit distinct addresses, so at
      // most one can forward to a given read.
      for (int j = 0; j < PORT_COUNT; j++) begin
        if (win[j] && in_rng[i] && a[j] == a[i])
          rd_word[i] = d[j];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == S_CLEAR)
        clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_CLEAR: if (clr_cnt == LAST) state_nx = S_RUN;
      S_RUN:   state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR)
        mem[clr_cnt] <= '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
        if (win[i])
          mem[idx[i]] <= d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid      <= '0;
      rdata       <= '0;
      wr_conflict <= '0;
      addr_err    <= '0;
    end else begin
      rvalid      <= rd_ok;
      wr_conflict <= lose;
      addr_err    <= {PORT_COUNT{run}} & req & ~in_rng;
      for (int i = 0; i < PORT_COUNT; i++) begin
        if (rd_ok[i])
          rdata[i*DATA_WIDTH +: DATA_WIDTH] <= rd_word[i];
      end
    end
  end

endmodule
